// File: rtl/requant_output_writer.sv
// Realigns per-channel int8 streams through small skew FIFOs and packs one byte per
// channel into NHWC words written to activation SRAM at base_addr + pixel index.
module requant_output_writer #(
  parameter int NUM_CHANNELS = 4,
  parameter int MAX_N        = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int PIX_BITS     = $clog2(MAX_N*MAX_N+1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [PIX_BITS-1:0]       num_pixels,
  input  logic                      in_valid [NUM_CHANNELS],
  input  logic signed [7:0]         in_data  [NUM_CHANNELS],
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [8*NUM_CHANNELS-1:0] mem_wdata,
  input  logic                      mem_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     base_q, base_d;
  logic [PIX_BITS-1:0]       num_q, num_d;
  logic [PIX_BITS-1:0]       pix_cnt_q, pix_cnt_d;
  logic                      mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]     mem_addr_q, mem_addr_d;
  logic [8*NUM_CHANNELS-1:0] mem_wdata_q, mem_wdata_d;
  logic                      overflow_q, overflow_d;

  logic [PW:0]               wr_ptr_q [NUM_CHANNELS];
  logic [PW:0]               wr_ptr_d [NUM_CHANNELS];
  logic [PW:0]               rd_ptr_q [NUM_CHANNELS];
  logic [PW:0]               rd_ptr_d [NUM_CHANNELS];
  logic [7:0]                fifo_mem_q [NUM_CHANNELS][FIFO_DEPTH];
  logic [7:0]                fifo_mem_d [NUM_CHANNELS][FIFO_DEPTH];

  logic [NUM_CHANNELS-1:0]   fifo_empty;
  logic [NUM_CHANNELS-1:0]   fifo_full;
  logic [NUM_CHANNELS-1:0]   push;
  logic [NUM_CHANNELS-1:0]   drop;
  logic                      run;
  logic                      pop;

  // FIFO status and the shared pop decision; a full FIFO still accepts a push when popping
  always_comb begin
    run = (state_q == S_RUN);
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      fifo_empty[ch] = (wr_ptr_q[ch] == rd_ptr_q[ch]);
      fifo_full[ch]  = ((wr_ptr_q[ch] - rd_ptr_q[ch]) == (PW+1)'(FIFO_DEPTH));
    end
    pop = run && !(|fifo_empty) && (!mem_we_q || mem_ready) && (pix_cnt_q != num_q);
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      push[ch] = run && in_valid[ch] && (!fifo_full[ch] || pop);
      drop[ch] = in_valid[ch] && !push[ch];
    end
  end

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (push[ch]) begin
        fifo_mem_d[ch][wr_ptr_q[ch][PW-1:0]] = in_data[ch];
        wr_ptr_d[ch] = wr_ptr_q[ch] + (PW+1)'(1);
      end
      if (pop) begin
        rd_ptr_d[ch] = rd_ptr_q[ch] + (PW+1)'(1);
      end
      // Leftover bytes from a finished tile must not leak into the next one
      if (state_q == S_DONE) begin
        wr_ptr_d[ch] = '0;
        rd_ptr_d[ch] = '0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    num_d       = num_q;
    pix_cnt_d   = pix_cnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    overflow_d  = overflow_q | (|drop);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d     = base_addr;
          num_d      = num_pixels;
          pix_cnt_d  = '0;
          overflow_d = |drop;
          state_d    = (num_pixels == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (pop) begin
          mem_we_d   = 1'b1;
          mem_addr_d = base_q + ADDR_WIDTH'(pix_cnt_q);
          for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            mem_wdata_d[8*ch +: 8] = fifo_mem_q[ch][rd_ptr_q[ch][PW-1:0]];
          end
          pix_cnt_d  = pix_cnt_q + PIX_BITS'(1);
        end else if (mem_we_q && mem_ready) begin
          mem_we_d = 1'b0;
          if (pix_cnt_q == num_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      num_q       <= '0;
      pix_cnt_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      overflow_q  <= 1'b0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        wr_ptr_q[ch] <= '0;
        rd_ptr_q[ch] <= '0;
      end
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      num_q       <= num_d;
      pix_cnt_q   <= pix_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Skew storage carries only data; validity lives in the reset pointers
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

endmodule
